// File: rtl/glyph_pkg.sv
// Shared types and constants for the glyph fetch stage and its shifter.
package glyph_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_WAIT = 2'd2
    } fetch_state_e;

    localparam int GLYPH_ROWS = 8;
    localparam int GLYPH_W    = 8;
    localparam int ADDR_W     = 8;

    function automatic logic [ADDR_W-1:0] glyph_addr(
        input logic [4:0] ch,
        input logic [2:0] row
    );
        return {ch, row};
    endfunction

endpackage

// File: rtl/glyph_shifter.sv
// One-byte holding buffer feeding an MSB-first pixel shifter.
// The buffer refills the shifter on the edge its last bit is consumed.
module glyph_shifter
    import glyph_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_load,
    input  logic [GLYPH_W-1:0] i_load_data,
    input  logic               i_pix_en,
    output logic               o_buf_full,
    output logic               o_pix,
    output logic               o_pix_valid
);

    localparam int CNT_W = $clog2(GLYPH_W);

    logic [GLYPH_W-1:0] buf_q;
    logic               buf_full_q;
    logic [GLYPH_W-1:0] sh_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               valid_q;

    logic consume;
    logic last;
    logic xfer;

    assign consume = i_pix_en & valid_q;
    assign last    = (cnt_q == '0);
    assign xfer    = buf_full_q & (~valid_q | (consume & last));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            sh_q       <= '0;
            cnt_q      <= '0;
            valid_q    <= 1'b0;
        end else begin
            if (i_load) begin
                buf_q      <= i_load_data;
                buf_full_q <= 1'b1;
            end else if (xfer) begin
                buf_full_q <= 1'b0;
            end
            if (xfer) begin
                sh_q    <= buf_q;
                cnt_q   <= CNT_W'(GLYPH_W - 1);
                valid_q <= 1'b1;
            end else if (consume) begin
                sh_q  <= {sh_q[GLYPH_W-2:0], 1'b0};
                cnt_q <= cnt_q - 1'b1;
                if (last)
                    valid_q <= 1'b0;
            end
        end
    end

    assign o_buf_full  = buf_full_q;
    assign o_pix       = valid_q & sh_q[GLYPH_W-1];
    assign o_pix_valid = valid_q;

endmodule

// File: rtl/glyph_fetch.sv
// Glyph fetch stage: one ROM read per request, byte serialised as pixels.
// Optional WAIT timeout enabled by GLYPH_FETCH_TIMEOUT_EN.
module glyph_fetch
    import glyph_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req,
    input  logic [4:0]        i_char,
    input  logic [2:0]        i_row,
    output logic              o_ready,
    output logic              o_rom_read,
    output logic [ADDR_W-1:0] o_rom_addr,
    input  logic [7:0]        i_rom_data,
    input  logic              i_rom_valid,
    input  logic              i_pix_en,
    output logic              o_pix,
    output logic              o_pix_valid,
    output logic              o_timeout
);

    fetch_state_e state_q;
    fetch_state_e state_d;

    logic [ADDR_W-1:0]  addr_q;
    logic               buf_full;
    logic               capture;
    logic [GLYPH_W-1:0] cap_data;
    logic               accept;

    assign o_ready    = (state_q == ST_IDLE) & ~buf_full;
    assign accept     = i_req & o_ready;
    assign o_rom_read = (state_q == ST_READ);
    assign o_rom_addr = addr_q;

`ifdef GLYPH_FETCH_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] wait_cnt_q;
    logic          fire;
    logic          timeout_q;

    assign fire = (state_q == ST_WAIT) & ~i_rom_valid
                & (wait_cnt_q == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            timeout_q <= fire;
            if (state_q != ST_WAIT)
                wait_cnt_q <= '0;
            else
                wait_cnt_q <= wait_cnt_q + 1'b1;
        end
    end

    assign o_timeout = timeout_q;
`else
    assign o_timeout = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        capture  = 1'b0;
        cap_data = i_rom_data;
        unique case (state_q)
            ST_IDLE: if (accept) state_d = ST_READ;
            ST_READ: state_d = ST_WAIT;
            ST_WAIT: begin
                if (i_rom_valid) begin
                    capture = 1'b1;
                    state_d = ST_IDLE;
                end
`ifdef GLYPH_FETCH_TIMEOUT_EN
                // abandoned read leaves a blank row so the line stays aligned
                else if (fire) begin
                    capture  = 1'b1;
                    cap_data = '0;
                    state_d  = ST_IDLE;
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept)
                addr_q <= glyph_addr(i_char, i_row);
        end
    end

    glyph_shifter u_shifter (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_load      (capture),
        .i_load_data (cap_data),
        .i_pix_en    (i_pix_en),
        .o_buf_full  (buf_full),
        .o_pix       (o_pix),
        .o_pix_valid (o_pix_valid)
    );

endmodule
